// File: rtl/or_arb_pkg.sv
// Shared defaults and FSM encoding for the shared OR-unit arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package or_arb_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 2;

  // IDLE: result register empty; HOLD: result register holds an undelivered result
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping N-1 -> 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is actually taken.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] cand;

  // Scan upward from ptr; N is a power of two so the IW-bit add wraps naturally
  always_comb begin
    cand  = '0;
    idx_o = '0;
    any_o = 1'b0;
    gnt_o = '0;
    for (int k = 0; k < N; k++) begin
      cand = ptr_i + IW'(k);
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
    if (any_o) begin
      gnt_o = N'(1) << idx_o;
    end
  end

endmodule

// File: rtl/or_unit_arbiter.sv
// N requesters share one registered bitwise-OR unit under round-robin arbitration.
// Latency: result valid one cycle after the grant cycle; one result per cycle sustained.
// Backpressure: out_ready low in HOLD freezes the result and withholds all grants.
module or_unit_arbiter
  import or_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   a_bus,
  input  logic [N_REQ*WIDTH-1:0]   b_bus,
  output logic [N_REQ-1:0]         grant,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(N_REQ)-1:0] out_id
);

  localparam int IW = $clog2(N_REQ);

  state_t           state_q;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    ptr_d;
  logic [WIDTH-1:0] out_data_q;
  logic [WIDTH-1:0] out_data_d;
  logic [IW-1:0]    out_id_q;

  logic [N_REQ-1:0] win_gnt;
  logic [IW-1:0]    win_idx;
  logic             win_any;
  logic             capture;

  rr_arbiter #(
    .N (N_REQ)
  ) u_rr (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (win_gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  // Capture when someone asks and the result slot is free or being drained this cycle
  assign capture = win_any && ((state_q == IDLE) || out_ready) && !rst;
  assign grant   = capture ? win_gnt : '0;
  assign ptr_d   = win_idx + IW'(1);

  // Select the winner's operands and OR them (no carry between bits)
  always_comb begin
    out_data_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == IW'(i)) begin
        out_data_d = a_bus[i*WIDTH +: WIDTH] | b_bus[i*WIDTH +: WIDTH];
      end
    end
  end

  // FSM plus result registers; reset drops any held result undelivered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      out_data_q <= '0;
      out_id_q   <= '0;
    end else if (capture) begin
      state_q    <= HOLD;
      ptr_q      <= ptr_d;
      out_data_q <= out_data_d;
      out_id_q   <= win_idx;
    end else if (state_q == HOLD && out_ready) begin
      state_q    <= IDLE;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_or_unit_arbiter.sv
// Directed bench for or_unit_arbiter with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Operands: r0=01|01=01, r1=10|11=11, r2=01|10=11, r3=10|00=10.
module tb_or_unit_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [7:0] a_bus;
  logic [7:0] b_bus;
  logic [3:0] grant;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_data;
  logic [1:0] out_id;

  int n_chk = 0;
  int n_err = 0;

  logic [1:0] exp_res [4];

  always #5 clk = ~clk;

  or_unit_arbiter #(.N_REQ(4), .WIDTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_bus     (a_bus),
    .b_bus     (b_bus),
    .grant     (grant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_res[0] = 2'b01;
    exp_res[1] = 2'b11;
    exp_res[2] = 2'b11;
    exp_res[3] = 2'b10;
    a_bus     = 8'b10_01_10_01;
    b_bus     = 8'b00_10_11_01;
    rst       = 1'b1;
    req       = 4'b1111;
    out_ready = 1'b0;

    // Reset held two cycles with everyone requesting
    step();
    step();
    @(negedge clk);
    chk("rst_grant", grant, 4'b0000);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 2'b00);
    chk("rst_id", out_id, 2'b00);

    // Release: search starts at index 0
    rst = 1'b0;
    #1;
    chk("rel_grant", grant, 4'b0001);
    step();
    req = 4'b0000;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rel_valid", out_valid, 1'b1);
    chk("rel_id", out_id, 2'd0);
    chk("rel_data", out_data, exp_res[0]);
    chk("rel_nogrant", grant, 4'b0000);

    // Drained to IDLE; single request from requester 2 (ptr=1)
    step();
    req = 4'b0100;
    @(negedge clk);
    chk("drain1_valid", out_valid, 1'b0);
    chk("drain1_keep", out_data, exp_res[0]);
    chk("single_grant", grant, 4'b0100);
    step();
    req = 4'b0010;
    @(negedge clk);
    chk("single_valid", out_valid, 1'b1);
    chk("single_data", out_data, 2'b11);
    chk("single_id", out_id, 2'd2);
    // ptr=3, only req1 asserted: wraps 3->0->1, back-to-back with delivery
    chk("skip_grant", grant, 4'b0010);
    step();
    req = 4'b0000;
    @(negedge clk);
    chk("skip_id", out_id, 2'd1);
    chk("skip_data", out_data, exp_res[1]);
    chk("skip_nogrant", grant, 4'b0000);
    step();
    @(negedge clk);
    chk("drain2_valid", out_valid, 1'b0);
    chk("drain2_keep_id", out_id, 2'd1);
    // ptr must now be 2
    req = 4'b1111;
    #1;
    chk("ptr_after_skip", grant, 4'b0100);
    rst = 1'b1;
    #1;
    chk("rst_kills_grant", grant, 4'b0000);
    step();
    rst = 1'b0;
    out_ready = 1'b1;

    // Fairness: all requesting, out_ready high
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr_grant", grant, 32'(4'b0001 << (k % 4)));
      if (k > 0) begin
        chk("rr_valid", out_valid, 1'b1);
        chk("rr_id", out_id, 32'((k - 1) % 4));
        chk("rr_data", out_data, exp_res[(k - 1) % 4]);
      end
      step();
    end

    // Backpressure: holding requester 0's result, ptr=1
    out_ready = 1'b0;
    req = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_grant", grant, 4'b0000);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_id", out_id, 2'd0);
      chk("bp_data", out_data, exp_res[0]);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_grant", grant, 4'b0010);
    chk("bp_rel_id", out_id, 2'd0);
    step();
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_next_id", out_id, 2'd1);
    chk("bp_next_data", out_data, exp_res[1]);
    chk("bp_next_nogrant", grant, 4'b0000);

    // Reset mid-HOLD: held result discarded, ptr back to 0
    rst = 1'b1;
    #1;
    chk("mid_rst_grant", grant, 4'b0000);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_data", out_data, 2'b00);
    chk("mid_rst_id", out_id, 2'd0);
    chk("mid_rst_ptr", grant, 4'b0001);
    step();
    req = 4'b0000;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_id", out_id, 2'd0);
    chk("post_rst_data", out_data, exp_res[0]);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
